// File: rtl/io_handshake_responder.sv
// io_handshake_responder: answers the core's OUTPUT/INPUT/PAUSE stalls from debounced board keys.
// Latency: pulse rises 1 cycle after the debounced press edge (2 + DEBOUNCE_CYCLES + 1 from a raw edge).
// Backpressure: the stall is released only by a key press; a held key must be released before it re-arms.
// Optional build macro IO_AUTO_ACK_EN: ignore keys and auto-acknowledge 8 cycles after arming.
module io_handshake_responder #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int SWITCH_WIDTH    = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    is_input,
  input  logic                    is_output,
  input  logic [31:0]             output_data,
  input  logic [SWITCH_WIDTH-1:0] switches,
  input  logic                    confirm_key,
  input  logic                    continue_key,
  output logic                    confirmation,
  output logic                    continue_button,
  output logic [31:0]             input_data,
  output logic [31:0]             display_value,
  output logic                    awaiting_user
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_ACK, ST_RELEASE} state_e;
  typedef enum logic [1:0] {MD_NONE, MD_OUT, MD_IN, MD_PAU} mode_e;

  // Key index 0 = confirm, 1 = continue.
  logic [1:0]    raw_keys;
  logic [1:0]    sync1_q, sync2_q, lvl_q, lvl_prev_q;
  logic [CW-1:0] cnt_q [2];
  logic [1:0]    press;

  assign raw_keys = {continue_key, confirm_key};
  assign press    = lvl_q & ~lvl_prev_q;

  // Synchronize each key, then accept a new level only after a full run of disagreeing samples.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      lvl_q      <= '0;
      lvl_prev_q <= '0;
      cnt_q[0]   <= '0;
      cnt_q[1]   <= '0;
    end else begin
      sync1_q    <= raw_keys;
      sync2_q    <= sync1_q;
      lvl_prev_q <= lvl_q;
      for (int k = 0; k < 2; k++) begin
        if (sync2_q[k] == lvl_q[k]) begin
          cnt_q[k] <= '0;
        end else if (cnt_q[k] == CNT_LAST) begin
          lvl_q[k] <= sync2_q[k];
          cnt_q[k] <= '0;
        end else begin
          cnt_q[k] <= cnt_q[k] + CW'(1);
        end
      end
    end
  end

  mode_e       req_mode, mode_q, mode_d;
  state_e      state_q, state_d;
  logic [31:0] disp_q, disp_d, in_q, in_d;
  logic        req_key_lvl, arm_key_lvl, arm_key_press;
  logic        idle_ok, fire, rel_ok;

  // Decode the core's request; both strobes together mean PAUSE.
  always_comb begin
    req_mode = MD_NONE;
    case ({is_output, is_input})
      2'b10:   req_mode = MD_OUT;
      2'b01:   req_mode = MD_IN;
      2'b11:   req_mode = MD_PAU;
      default: req_mode = MD_NONE;
    endcase
  end

  assign req_key_lvl   = (req_mode == MD_PAU) ? lvl_q[1] : lvl_q[0];
  assign arm_key_lvl   = (mode_q   == MD_PAU) ? lvl_q[1] : lvl_q[0];
  assign arm_key_press = (mode_q   == MD_PAU) ? press[1] : press[0];

`ifdef IO_AUTO_ACK_EN
  logic [2:0] auto_cnt_q;
  logic       unused_keys;

  // Count cycles spent armed; the eighth armed cycle acknowledges.
  always_ff @(posedge clock) begin
    if (reset || state_q != ST_ARMED) begin
      auto_cnt_q <= '0;
    end else begin
      auto_cnt_q <= auto_cnt_q + 3'd1;
    end
  end

  assign idle_ok     = 1'b1;
  assign fire        = (auto_cnt_q == 3'd7);
  assign rel_ok      = 1'b1;
  assign unused_keys = ^{req_key_lvl, arm_key_lvl, arm_key_press};
`else
  assign idle_ok = ~req_key_lvl;
  assign fire    = arm_key_press;
  assign rel_ok  = ~arm_key_lvl;
`endif

  // Handshake state, registered mode and the two data latches.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      mode_q  <= MD_NONE;
      disp_q  <= '0;
      in_q    <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      disp_q  <= disp_d;
      in_q    <= in_d;
    end
  end

  // Next-state logic: arm on a request with its key released, acknowledge on a fresh press.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    disp_d  = disp_q;
    in_d    = in_q;
    case (state_q)
      ST_IDLE: begin
        if (req_mode != MD_NONE && idle_ok) begin
          state_d = ST_ARMED;
          mode_d  = req_mode;
          if (req_mode == MD_OUT) disp_d = output_data;
        end
      end
      ST_ARMED: begin
        if (req_mode != mode_q) begin
          state_d = ST_IDLE;
        end else if (fire) begin
          state_d = ST_ACK;
          if (mode_q == MD_IN) in_d = 32'(switches);
        end
      end
      ST_ACK:     state_d = ST_RELEASE;
      ST_RELEASE: if (rel_ok) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  assign confirmation    = (state_q == ST_ACK) && (mode_q != MD_PAU);
  assign continue_button = (state_q == ST_ACK) && (mode_q == MD_PAU);
  assign awaiting_user   = (state_q == ST_ARMED);
  assign input_data      = in_q;
  assign display_value   = disp_q;

endmodule
